rmt_action_crossbar: RTL and testbench

- Per-stage operand crossbar of the RMT action engine, sitting between the action RAM/PHV input and the ALU array.
- For each of the 24 PHV containers (8×6B, 8×4B, 8×2B) it decodes that container's 25-bit action word. It then selects two ALU operands (a PHV container or an immediate) and registers them with the untouched PHV remainder.

---
 rtl/rmt_action_crossbar_pkg.sv | 34 +++
 rtl/rmt_action_crossbar_lane.sv | 41 ++++
 rtl/rmt_action_crossbar.sv | 127 ++++++++++++
 tb/tb_rmt_action_crossbar.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_action_crossbar_pkg.sv
// Shared constants for the RMT action operand crossbar: container widths,
// PHV layout, action-word field offsets, opcode encodings and slot bases.
package rmt_action_crossbar_pkg;

    localparam int PHV_LEN    = 1124;
    localparam int ACT_LEN    = 25;
    localparam int NUM_SLOTS  = 25;
    localparam int NUM_CONT   = 8;

    localparam int W2B        = 16;
    localparam int W4B        = 32;
    localparam int W6B        = 48;

    // Action word: op[24:21], idx1[20:16], idx2[15:11], imm[15:0]
    localparam int OP_LSB     = 21;
    localparam int OP_W       = 4;
    localparam int IDX1_LSB   = 16;
    localparam int IDX2_LSB   = 11;
    localparam int IDX_W      = 5;
    localparam int IDX_USED_W = 3;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;

    localparam int              OP_IMM_BIT = 3;
    localparam logic [OP_W-1:0] OP_NOP     = 4'b0000;

    localparam int SLOT_6B    = 17;
    localparam int SLOT_4B    = 9;
    localparam int SLOT_2B    = 1;

    localparam int VLAN_LSB   = 128;
    localparam int VLAN_W     = 12;

endpackage

// File: rtl/rmt_action_crossbar_lane.sv
// One container lane: decodes its action word and picks operand 1/2 from the
// eight same-width containers, an immediate, or its own value for a NOP.
module crossbar_lane
    import rmt_action_crossbar_pkg::*;
#(
    parameter int WIDTH = W6B
) (
    input  logic [NUM_CONT*WIDTH-1:0] cont_i,
    input  logic [WIDTH-1:0]          own_i,
    input  logic [ACT_LEN-1:0]        action_i,
    output logic [WIDTH-1:0]          op1_o,
    output logic [WIDTH-1:0]          op2_o
);

    logic [OP_W-1:0]       op;
    logic [IDX_USED_W-1:0] idx1;
    logic [IDX_USED_W-1:0] idx2;
    logic [IMM_W-1:0]      imm;
    logic                  unused_ok;

    assign op   = action_i[OP_LSB +: OP_W];
    assign idx1 = action_i[IDX1_LSB +: IDX_USED_W];
    assign idx2 = action_i[IDX2_LSB +: IDX_USED_W];
    assign imm  = action_i[IMM_LSB +: IMM_W];

    // Upper idx1 bits are never used; idx2's upper bits overlap imm.
    assign unused_ok = ^action_i[IDX1_LSB+IDX_USED_W +: IDX_W-IDX_USED_W];

    always_comb begin
        op1_o = cont_i[idx1*WIDTH +: WIDTH];
        op2_o = '0;
        if (op == OP_NOP) begin
            op1_o = own_i;
        end else if (op[OP_IMM_BIT]) begin
            op2_o[IMM_W-1:0] = imm;
        end else begin
            op2_o = cont_i[idx2*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/rmt_action_crossbar.sv
// Per-stage operand crossbar feeding the ALU array; one-cycle registered path.
// Optional build macro CROSSBAR_ACTION_GATE_EN gates validity/ops with action_in_valid.
module rmt_action_crossbar
    import rmt_action_crossbar_pkg::*;
#(
    parameter int STAGE    = 0,
    parameter int PHV_LEN  = rmt_action_crossbar_pkg::PHV_LEN,
    parameter int ACT_LEN  = rmt_action_crossbar_pkg::ACT_LEN,
    parameter int width_2B = W2B,
    parameter int width_4B = W4B,
    parameter int width_6B = W6B
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PHV_LEN-1:0]           phv_in,
    input  logic                         phv_in_valid,
    input  logic [ACT_LEN*NUM_SLOTS-1:0] action_in,
    input  logic                         action_in_valid,
    output logic [VLAN_W-1:0]            vlan_id,
    output logic                         alu_in_valid,
    output logic [NUM_CONT*width_6B-1:0] alu_in_6B_1,
    output logic [NUM_CONT*width_6B-1:0] alu_in_6B_2,
    output logic [NUM_CONT*width_4B-1:0] alu_in_4B_1,
    output logic [NUM_CONT*width_4B-1:0] alu_in_4B_2,
    output logic [NUM_CONT*width_4B-1:0] alu_in_4B_3,
    output logic [NUM_CONT*width_2B-1:0] alu_in_2B_1,
    output logic [NUM_CONT*width_2B-1:0] alu_in_2B_2,
    output logic [PHV_LEN-NUM_CONT*(width_6B+width_4B+width_2B)-1:0] phv_remain_data
);

    localparam int REMAIN_LEN   = PHV_LEN - NUM_CONT*(width_6B+width_4B+width_2B);
    localparam int OFF_2B       = REMAIN_LEN;
    localparam int OFF_4B       = OFF_2B + NUM_CONT*width_2B;
    localparam int OFF_6B       = OFF_4B + NUM_CONT*width_4B;
    localparam int unused_stage = STAGE;

    logic [ACT_LEN*NUM_SLOTS-1:0] act_eff;
    logic                         valid_d;
    logic                         unused_ok;

`ifdef CROSSBAR_ACTION_GATE_EN
    // Without a valid action every slot decodes as NOP, so operands pass through.
    assign act_eff   = action_in_valid ? action_in : '0;
    assign valid_d   = phv_in_valid & action_in_valid;
    assign unused_ok = ^act_eff[ACT_LEN-1:0];
`else
    assign act_eff   = action_in;
    assign valid_d   = phv_in_valid;
    assign unused_ok = ^{action_in_valid, act_eff[ACT_LEN-1:0]};
`endif

    logic [NUM_CONT*width_6B-1:0] a6_1_d, a6_2_d;
    logic [NUM_CONT*width_4B-1:0] a4_1_d, a4_2_d;
    logic [NUM_CONT*width_2B-1:0] a2_1_d, a2_2_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONT; gi++) begin : g_lane
            crossbar_lane #(.WIDTH(width_6B)) u_lane_6b (
                .cont_i   (phv_in[OFF_6B +: NUM_CONT*width_6B]),
                .own_i    (phv_in[OFF_6B + gi*width_6B +: width_6B]),
                .action_i (act_eff[(SLOT_6B+gi)*ACT_LEN +: ACT_LEN]),
                .op1_o    (a6_1_d[gi*width_6B +: width_6B]),
                .op2_o    (a6_2_d[gi*width_6B +: width_6B])
            );
            crossbar_lane #(.WIDTH(width_4B)) u_lane_4b (
                .cont_i   (phv_in[OFF_4B +: NUM_CONT*width_4B]),
                .own_i    (phv_in[OFF_4B + gi*width_4B +: width_4B]),
                .action_i (act_eff[(SLOT_4B+gi)*ACT_LEN +: ACT_LEN]),
                .op1_o    (a4_1_d[gi*width_4B +: width_4B]),
                .op2_o    (a4_2_d[gi*width_4B +: width_4B])
            );
            crossbar_lane #(.WIDTH(width_2B)) u_lane_2b (
                .cont_i   (phv_in[OFF_2B +: NUM_CONT*width_2B]),
                .own_i    (phv_in[OFF_2B + gi*width_2B +: width_2B]),
                .action_i (act_eff[(SLOT_2B+gi)*ACT_LEN +: ACT_LEN]),
                .op1_o    (a2_1_d[gi*width_2B +: width_2B]),
                .op2_o    (a2_2_d[gi*width_2B +: width_2B])
            );
        end
    endgenerate

    logic                         valid_q;
    logic [VLAN_W-1:0]            vlan_q;
    logic [REMAIN_LEN-1:0]        remain_q;
    logic [NUM_CONT*width_6B-1:0] a6_1_q, a6_2_q;
    logic [NUM_CONT*width_4B-1:0] a4_1_q, a4_2_q, a4_3_q;
    logic [NUM_CONT*width_2B-1:0] a2_1_q, a2_2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            vlan_q   <= '0;
            remain_q <= '0;
            a6_1_q   <= '0;
            a6_2_q   <= '0;
            a4_1_q   <= '0;
            a4_2_q   <= '0;
            a4_3_q   <= '0;
            a2_1_q   <= '0;
            a2_2_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            vlan_q   <= phv_in[VLAN_LSB +: VLAN_W];
            remain_q <= phv_in[REMAIN_LEN-1:0];
            a6_1_q   <= a6_1_d;
            a6_2_q   <= a6_2_d;
            a4_1_q   <= a4_1_d;
            a4_2_q   <= a4_2_d;
            a4_3_q   <= phv_in[OFF_4B +: NUM_CONT*width_4B];
            a2_1_q   <= a2_1_d;
            a2_2_q   <= a2_2_d;
        end
    end

    assign alu_in_valid    = valid_q;
    assign vlan_id         = vlan_q;
    assign phv_remain_data = remain_q;
    assign alu_in_6B_1     = a6_1_q;
    assign alu_in_6B_2     = a6_2_q;
    assign alu_in_4B_1     = a4_1_q;
    assign alu_in_4B_2     = a4_2_q;
    assign alu_in_4B_3     = a4_3_q;
    assign alu_in_2B_1     = a2_1_q;
    assign alu_in_2B_2     = a2_2_q;

endmodule

// File: tb/tb_rmt_action_crossbar.sv
// Self-checking bench for rmt_action_crossbar: directed scenarios plus
// randomized traffic against a container-level reference model.
module tb_rmt_action_crossbar;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1123:0]  phv_in;
    logic           phv_in_valid;
    logic [624:0]   action_in;
    logic           action_in_valid;
    logic [11:0]    vlan_id;
    logic           alu_in_valid;
    logic [383:0]   alu_in_6B_1, alu_in_6B_2;
    logic [255:0]   alu_in_4B_1, alu_in_4B_2, alu_in_4B_3;
    logic [127:0]   alu_in_2B_1, alu_in_2B_2;
    logic [355:0]   phv_remain_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rmt_action_crossbar dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .action_in       (action_in),
        .action_in_valid (action_in_valid),
        .vlan_id         (vlan_id),
        .alu_in_valid    (alu_in_valid),
        .alu_in_6B_1     (alu_in_6B_1),
        .alu_in_6B_2     (alu_in_6B_2),
        .alu_in_4B_1     (alu_in_4B_1),
        .alu_in_4B_2     (alu_in_4B_2),
        .alu_in_4B_3     (alu_in_4B_3),
        .alu_in_2B_1     (alu_in_2B_1),
        .alu_in_2B_2     (alu_in_2B_2),
        .phv_remain_data (phv_remain_data)
    );

    // ---------------- reference model (class 0=2B, 1=4B, 2=6B) ----------------
    function automatic int cls_w(input int cls);
        return (cls == 2) ? 48 : (cls == 1) ? 32 : 16;
    endfunction

    function automatic int cls_base(input int cls);
        return (cls == 2) ? 740 : (cls == 1) ? 484 : 356;
    endfunction

    function automatic int cls_slot(input int cls);
        return (cls == 2) ? 17 : (cls == 1) ? 9 : 1;
    endfunction

    function automatic logic [47:0] get_c(input logic [1123:0] p, input int cls, input int k);
        logic [47:0] r = '0;
        for (int b = 0; b < cls_w(cls); b++) r[b] = p[cls_base(cls) + cls_w(cls)*k + b];
        return r;
    endfunction

    function automatic logic [1123:0] set_c(input logic [1123:0] p, input int cls, input int k,
                                            input logic [47:0] v);
        logic [1123:0] r = p;
        for (int b = 0; b < cls_w(cls); b++) r[cls_base(cls) + cls_w(cls)*k + b] = v[b];
        return r;
    endfunction

    function automatic logic [47:0] exp_op(input logic [1123:0] p, input logic [624:0] a,
                                           input logic av, input int cls, input int k,
                                           input int which);
        logic [24:0] w = a[(cls_slot(cls)+k)*25 +: 25];
        int op   = int'(w[24:21]);
        int i1   = int'(w[20:16]) % 8;
        int i2   = int'(w[15:11]) % 8;
`ifdef CROSSBAR_ACTION_GATE_EN
        if (!av) op = 0;
`else
        if (av) op = op;
`endif
        if (op == 0) return (which == 1) ? get_c(p, cls, k) : 48'd0;
        if (which == 1) return get_c(p, cls, i1);
        if (op >= 8) return {32'd0, w[15:0]};
        return get_c(p, cls, i2);
    endfunction

    function automatic logic exp_valid(input logic pv, input logic av);
`ifdef CROSSBAR_ACTION_GATE_EN
        return pv & av;
`else
        return pv | (av & 1'b0);
`endif
    endfunction

    function automatic logic [47:0] act_op(input int cls, input int k, input int which);
        case (cls)
            2: return (which == 1) ? alu_in_6B_1[k*48 +: 48] : alu_in_6B_2[k*48 +: 48];
            1: return {16'd0, (which == 1) ? alu_in_4B_1[k*32 +: 32] : alu_in_4B_2[k*32 +: 32]};
            default: return {32'd0, (which == 1) ? alu_in_2B_1[k*16 +: 16] : alu_in_2B_2[k*16 +: 16]};
        endcase
    endfunction

    function automatic logic [1123:0] rand_phv();
        logic [1123:0] r;
        for (int b = 0; b < 1124; b += 32) r[b +: 32] = 32'($urandom) ;
        return r;
    endfunction

    task automatic step(input logic [1123:0] p, input logic [624:0] a, input logic pv, input logic av);
        phv_in = p; action_in = a; phv_in_valid = pv; action_in_valid = av;
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2631:0] all_out;
        rst_n = 1'b0;
        step(rand_phv(), {20{32'($urandom)}}, 1'b1, 1'b1);
        step(rand_phv(), {20{32'($urandom)}}, 1'b1, 1'b1);
        all_out = {vlan_id, alu_in_valid, alu_in_6B_1, alu_in_6B_2, alu_in_4B_1, alu_in_4B_2,
                   alu_in_4B_3, alu_in_2B_1, alu_in_2B_2, phv_remain_data};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero bits=%0d required 0", $countones(all_out));
        end
        $display("reset: outputs checked");
        rst_n = 1'b1;
    endtask

    task automatic test_swap_6b();
        logic [1123:0] p = '0;
        logic [624:0]  a = '0;
        p = set_c(p, 2, 7, 48'hfffffffffffe);
        p = set_c(p, 2, 6, 48'heeeeeeeeeeef);
        a[600 +: 25] = {4'b0001, 5'd6, 5'd7, 11'b0};
        step(p, a, 1'b1, 1'b1);
        checks += 3;
        if (alu_in_valid !== 1'b1) begin errors++; $display("FAIL swap_valid: got %b required 1", alu_in_valid); end
        if (alu_in_6B_1[383:336] !== 48'heeeeeeeeeeef) begin
            errors++; $display("FAIL swap_op1: got %h required eeeeeeeeeeef", alu_in_6B_1[383:336]);
        end
        if (alu_in_6B_2[383:336] !== 48'hfffffffffffe) begin
            errors++; $display("FAIL swap_op2: got %h required fffffffffffe", alu_in_6B_2[383:336]);
        end
        $display("swap_6b: op1=%h op2=%h", alu_in_6B_1[383:336], alu_in_6B_2[383:336]);
    endtask

    task automatic test_imm_and_nop();
        logic [1123:0] p = rand_phv();
        logic [624:0]  a = '0;
        logic [47:0]   c0;
        p  = set_c(p, 2, 7, 48'hffffffffffff);
        p  = set_c(p, 2, 6, 48'heeeeeeeeeeee);
        c0 = get_c(p, 2, 0);
        a[600 +: 25] = {4'b1010, 5'd6, 16'hffff};
        step(p, a, 1'b1, 1'b1);
        checks += 2;
        if (alu_in_6B_1[383:336] !== 48'heeeeeeeeeeee) begin
            errors++; $display("FAIL imm_op1: got %h required eeeeeeeeeeee", alu_in_6B_1[383:336]);
        end
        if (alu_in_6B_2[383:336] !== 48'h00000000ffff) begin
            errors++; $display("FAIL imm_op2: got %h required 00000000ffff", alu_in_6B_2[383:336]);
        end
        $display("immediate: op1=%h op2=%h", alu_in_6B_1[383:336], alu_in_6B_2[383:336]);
        a[600 +: 25] = {4'b0000, 5'd6, 16'hffff};
        step(p, a, 1'b1, 1'b1);
        checks += 4;
        if (alu_in_6B_1[383:336] !== 48'hffffffffffff) begin
            errors++; $display("FAIL nop_op1: got %h required ffffffffffff", alu_in_6B_1[383:336]);
        end
        if (alu_in_6B_2[383:336] !== 48'd0) begin
            errors++; $display("FAIL nop_op2: got %h required 0", alu_in_6B_2[383:336]);
        end
        if (alu_in_6B_1[47:0] !== c0) begin
            errors++; $display("FAIL nop_c0_op1: got %h required %h", alu_in_6B_1[47:0], c0);
        end
        if (alu_in_6B_2[47:0] !== 48'd0) begin
            errors++; $display("FAIL nop_c0_op2: got %h required 0", alu_in_6B_2[47:0]);
        end
        $display("nop: op1=%h op2=%h", alu_in_6B_1[383:336], alu_in_6B_2[383:336]);
    endtask

    task automatic test_classes();
        logic [1123:0] p = rand_phv();
        logic [624:0]  a = '0;
        logic [15:0]   c2_7;
        p = set_c(p, 1, 3, 48'h11111111);
        p = set_c(p, 1, 5, 48'h22222222);
        c2_7 = get_c(p, 0, 7);
        a[225 +: 25] = {4'b0001, 5'd3, 5'd5, 11'b0};
        a[25 +: 25]  = {4'b1000, 5'd7, 16'h1234};
        step(p, a, 1'b1, 1'b1);
        checks += 5;
        if (alu_in_4B_1[31:0] !== 32'h11111111) begin
            errors++; $display("FAIL class4_op1: got %h required 11111111", alu_in_4B_1[31:0]);
        end
        if (alu_in_4B_2[31:0] !== 32'h22222222) begin
            errors++; $display("FAIL class4_op2: got %h required 22222222", alu_in_4B_2[31:0]);
        end
        if (alu_in_4B_3 !== p[484 +: 256]) begin
            errors++; $display("FAIL class4_orig: got %h required %h", alu_in_4B_3, p[484 +: 256]);
        end
        if (alu_in_2B_1[15:0] !== c2_7) begin
            errors++; $display("FAIL class2_op1: got %h required %h", alu_in_2B_1[15:0], c2_7);
        end
        if (alu_in_2B_2[15:0] !== 16'h1234) begin
            errors++; $display("FAIL class2_op2: got %h required 1234", alu_in_2B_2[15:0]);
        end
        $display("classes: 4B op1=%h op2=%h 2B op1=%h op2=%h", alu_in_4B_1[31:0],
                 alu_in_4B_2[31:0], alu_in_2B_1[15:0], alu_in_2B_2[15:0]);
    endtask

    task automatic test_valid_reset();
        logic [2631:0] all_out;
        step(rand_phv(), '0, 1'b0, 1'b0);
        phv_in_valid = 1'b1; action_in_valid = 1'b1;
        checks++;
        if (alu_in_valid !== 1'b0) begin errors++; $display("FAIL pulse_pre: got %b required 0", alu_in_valid); end
        step(rand_phv(), '0, 1'b1, 1'b1);
        checks++;
        if (alu_in_valid !== 1'b1) begin errors++; $display("FAIL pulse_on: got %b required 1", alu_in_valid); end
        step(rand_phv(), '0, 1'b0, 1'b1);
        checks++;
        if (alu_in_valid !== 1'b0) begin errors++; $display("FAIL pulse_off: got %b required 0", alu_in_valid); end
        rst_n = 1'b0;
        step(rand_phv(), {20{32'($urandom)}}, 1'b1, 1'b1);
        all_out = {vlan_id, alu_in_valid, alu_in_6B_1, alu_in_6B_2, alu_in_4B_1, alu_in_4B_2,
                   alu_in_4B_3, alu_in_2B_1, alu_in_2B_2, phv_remain_data};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL midreset_outputs: got nonzero bits=%0d required 0", $countones(all_out));
        end
        rst_n = 1'b1;
        $display("valid_reset: pulse and mid-stream reset checked");
    endtask

    task automatic test_random();
        logic [1123:0] p;
        logic [624:0]  a;
        logic          pv, av;
        logic [47:0]   e;
        for (int t = 0; t < 40; t++) begin
            p = rand_phv();
            for (int b = 0; b < 625; b += 25) a[b +: 25] = 25'($urandom);
            pv = 1'($urandom); av = 1'($urandom);
            step(p, a, pv, av);
            checks += 4;
            if (alu_in_valid !== exp_valid(pv, av)) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b required %b", t, alu_in_valid, exp_valid(pv, av));
            end
            if (phv_remain_data !== p[355:0]) begin
                errors++; $display("FAIL rand_remain[%0d]: got %h required %h", t, phv_remain_data, p[355:0]);
            end
            if (vlan_id !== p[139:128]) begin
                errors++; $display("FAIL rand_vlan[%0d]: got %h required %h", t, vlan_id, p[139:128]);
            end
            if (alu_in_4B_3 !== p[484 +: 256]) begin
                errors++; $display("FAIL rand_orig4B[%0d]: got %h required %h", t, alu_in_4B_3, p[484 +: 256]);
            end
            for (int cls = 0; cls < 3; cls++) begin
                for (int k = 0; k < 8; k++) begin
                    for (int w = 1; w <= 2; w++) begin
                        e = exp_op(p, a, av, cls, k, w);
                        checks++;
                        if (act_op(cls, k, w) !== e) begin
                            errors++;
                            $display("FAIL rand_op[%0d] cls=%0d c=%0d op%0d: got %h required %h",
                                     t, cls, k, w, act_op(cls, k, w), e);
                        end
                    end
                end
            end
            $display("random[%0d]: pv=%b av=%b valid=%b", t, pv, av, alu_in_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; phv_in = '0; action_in = '0; phv_in_valid = 1'b0; action_in_valid = 1'b0;
        test_reset();
        test_swap_6b();
        test_imm_and_nop();
        test_classes();
        test_valid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
